// File: rtl/ncu_mcu_upstream_rx.sv
// NCU receiver for one MCU upstream nibble channel: deserialises nibbles into
// fixed-size packets, buffers them in a small FIFO and drives stall/error flags.
module ncu_mcu_upstream_rx #(
   parameter int PKT_NIBBLES = 32,
   parameter int FIFO_DEPTH  = 2,
   parameter int CNT_W       = 16
) (
   input  logic                     iol2clk,
   input  logic                     rst_l,
   input  logic                     mcu_ncu_vld,
   input  logic [3:0]               mcu_ncu_data,
   output logic                     ncu_mcu_stall,
   output logic                     pkt_vld,
   output logic [4*PKT_NIBBLES-1:0] pkt_data,
   input  logic                     pkt_rdy,
   output logic                     err_proto,
   output logic                     err_ovf,
   output logic [CNT_W-1:0]         pkt_count
);

   localparam int PW    = 4 * PKT_NIBBLES;
   localparam int IDX_W = (PKT_NIBBLES > 1) ? $clog2(PKT_NIBBLES) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FC_W  = $clog2(FIFO_DEPTH + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_NIBBLES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [FC_W-1:0]  FC_FULL  = FC_W'(FIFO_DEPTH);
   localparam logic [FC_W:0]    OCC_FULL = (FC_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ASM,
      DROP
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  idx;
   logic [PW-5:0]     asm_sr;
   logic [PW-1:0]     wr_data;
   logic [PW-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FC_W-1:0]   fifo_cnt;
   logic [FC_W-1:0]   fifo_cnt_next;
   logic [FC_W:0]     occ_next;
   logic              pop;
   logic              room;
   logic              start;
   logic              ovf_now;
   logic              wr_en;
   logic              proto_now;

   always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mcu_ncu_vld) state_next = room ? ASM : DROP;
         ASM:     if (idx == IDX_LAST) state_next = IDLE;
         DROP:    if (idx == IDX_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pkt_vld   = (fifo_cnt != '0);
      pop       = pkt_vld && pkt_rdy;
      room      = (fifo_cnt < FC_FULL) || pop;
      start     = (state == IDLE) && mcu_ncu_vld && room;
      ovf_now   = (state == IDLE) && mcu_ncu_vld && !room;
      wr_en     = (state == ASM) && (idx == IDX_LAST);
      proto_now = (state != IDLE) && mcu_ncu_vld;
      pkt_data  = mem[rd_ptr];
   end

   // Nibble index doubles as the drop counter while discarding an overflowed packet.
   always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
         idx <= '0;
      end else if (state == IDLE) begin
         idx <= mcu_ncu_vld ? IDX_W'(1) : '0;
      end else begin
         idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
   end

   // Shift register holds nibbles 0..N-2; the final nibble joins on the write cycle.
   always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
         asm_sr <= '0;
      end else if (start || (state == ASM)) begin
         asm_sr <= {mcu_ncu_data, asm_sr[PW-5:4]};
      end
   end

   assign wr_data = {mcu_ncu_data, asm_sr};

   always_comb begin
      fifo_cnt_next = fifo_cnt;
      case ({wr_en, pop})
         2'b10:   fifo_cnt_next = fifo_cnt + FC_W'(1);
         2'b01:   fifo_cnt_next = fifo_cnt - FC_W'(1);
         default: fifo_cnt_next = fifo_cnt;
      endcase
      occ_next = {1'b0, fifo_cnt_next} + (FC_W + 1)'(state_next == ASM);
   end

   always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         fifo_cnt <= fifo_cnt_next;
      end
   end

   always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
         ncu_mcu_stall <= 1'b0;
         err_proto     <= 1'b0;
         err_ovf       <= 1'b0;
         pkt_count     <= '0;
      end else begin
         ncu_mcu_stall <= (occ_next >= OCC_FULL);
         err_proto     <= proto_now;
         err_ovf       <= ovf_now;
         if (wr_en && (pkt_count != '1)) begin
            pkt_count <= pkt_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ncu_mcu_upstream_rx.sv
// Directed bench for ncu_mcu_upstream_rx: table of single-packet vectors plus
// hand-written sequences for backpressure, overflow, protocol error, reset and saturation.
module tb_ncu_mcu_upstream_rx;

   localparam int TB_CNT_W = 3;   // narrow counter so saturation is reachable quickly

   logic                iol2clk = 1'b0;
   logic                rst_l = 1'b0;
   logic                mcu_ncu_vld = 1'b0;
   logic [3:0]          mcu_ncu_data = 4'h0;
   logic                ncu_mcu_stall;
   logic                pkt_vld;
   logic [127:0]        pkt_data;
   logic                pkt_rdy = 1'b0;
   logic                err_proto;
   logic                err_ovf;
   logic [TB_CNT_W-1:0] pkt_count;

   int n_chk  = 0;
   int n_fail = 0;

   ncu_mcu_upstream_rx #(
      .PKT_NIBBLES (32),
      .FIFO_DEPTH  (2),
      .CNT_W       (TB_CNT_W)
   ) dut (
      .iol2clk       (iol2clk),
      .rst_l         (rst_l),
      .mcu_ncu_vld   (mcu_ncu_vld),
      .mcu_ncu_data  (mcu_ncu_data),
      .ncu_mcu_stall (ncu_mcu_stall),
      .pkt_vld       (pkt_vld),
      .pkt_data      (pkt_data),
      .pkt_rdy       (pkt_rdy),
      .err_proto     (err_proto),
      .err_ovf       (err_ovf),
      .pkt_count     (pkt_count)
   );

   always #5 iol2clk = ~iol2clk;

   typedef struct {
      logic [3:0]          base;
      logic [3:0]          step;
      logic [127:0]        exp_data;
      logic [TB_CNT_W-1:0] exp_count;
   } vec_t;

   vec_t tbl [4];

   localparam logic [127:0] P_0_1 = 128'hFEDCBA98_76543210_FEDCBA98_76543210;
   localparam logic [127:0] P_1_1 = 128'h0FEDCBA9_87654321_0FEDCBA9_87654321;
   localparam logic [127:0] P_8_3 = 128'h52FC9630_DA741EB8_52FC9630_DA741EB8;
   localparam logic [127:0] P_0_2 = 128'hECA86420_ECA86420_ECA86420_ECA86420;
   localparam logic [127:0] P_3_0 = 128'h33333333_33333333_33333333_33333333;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input string name, input logic [TB_CNT_W-1:0] act,
                          input logic [TB_CNT_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iol2clk);
      #1;
   endtask

   task automatic nibble(input logic v, input logic [3:0] d);
      mcu_ncu_vld  = v;
      mcu_ncu_data = d;
      tick();
   endtask

   function automatic logic [3:0] pat(input logic [3:0] b, input logic [3:0] s, input int k);
      logic [3:0] kk;
      kk = 4'(k);
      return b + s * kk;
   endfunction

   task automatic send_pkt(input logic [3:0] b, input logic [3:0] s, input bit lat);
      for (int k = 0; k < 32; k++) begin
         if (lat && k == 31) chk_bit("latency_pre", pkt_vld, 1'b0);
         nibble(k == 0, pat(b, s, k));
      end
      mcu_ncu_vld = 1'b0;
      if (lat) chk_bit("latency_vld", pkt_vld, 1'b1);
   endtask

   task automatic pop();
      pkt_rdy = 1'b1;
      tick();
      pkt_rdy = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{4'h0, 4'h1, P_0_1, 3'd1};
      tbl[1] = '{4'hF, 4'h0, {32{4'hF}}, 3'd2};
      tbl[2] = '{4'hF, 4'hF, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 3'd3};
      tbl[3] = '{4'h0, 4'h2, P_0_2, 3'd4};

      tick();
      tick();
      chk_bit("rst_stall", ncu_mcu_stall, 1'b0);
      chk_bit("rst_pkt_vld", pkt_vld, 1'b0);
      chk_bit("rst_err_proto", err_proto, 1'b0);
      chk_bit("rst_err_ovf", err_ovf, 1'b0);
      chk_cnt("rst_count", pkt_count, '0);
      chk_vec("rst_data", pkt_data, '0);
      rst_l = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         send_pkt(tbl[i].base, tbl[i].step, 1'b1);
         chk_vec("tbl_data", pkt_data, tbl[i].exp_data);
         chk_cnt("tbl_count", pkt_count, tbl[i].exp_count);
         chk_bit("tbl_stall", ncu_mcu_stall, 1'b0);
         pop();
         chk_bit("tbl_popped", pkt_vld, 1'b0);
      end

      // Back-to-back packets with consumer stalled, then overflow and drop window
      send_pkt(4'h1, 4'h1, 1'b0);
      chk_bit("t2_stall_one", ncu_mcu_stall, 1'b0);
      for (int k = 0; k < 32; k++) begin
         nibble(k == 0, pat(4'h8, 4'h3, k));
         if (k == 0) chk_bit("t2_stall_after_start", ncu_mcu_stall, 1'b1);
      end
      chk_cnt("t2_count", pkt_count, 3'd6);
      chk_bit("t2_stall_full", ncu_mcu_stall, 1'b1);
      chk_vec("t2_head", pkt_data, P_1_1);
      nibble(1'b1, 4'h7);
      chk_bit("t2_ovf", err_ovf, 1'b1);
      chk_cnt("t2_count_ovf", pkt_count, 3'd6);
      nibble(1'b0, 4'h0);
      chk_bit("t2_ovf_pulse", err_ovf, 1'b0);
      nibble(1'b1, 4'h2);
      chk_bit("t2_drop_proto", err_proto, 1'b1);
      chk_bit("t2_drop_no_ovf", err_ovf, 1'b0);
      repeat (31) nibble(1'b0, 4'h0);
      chk_cnt("t2_count_drop", pkt_count, 3'd6);
      chk_vec("t2_head_kept", pkt_data, P_1_1);
      pop();
      chk_vec("t2_second", pkt_data, P_8_3);
      chk_bit("t2_unstall", ncu_mcu_stall, 1'b0);
      pop();
      chk_bit("t2_empty", pkt_vld, 1'b0);

      // vld re-asserted mid-packet
      for (int k = 0; k < 32; k++) begin
         nibble(k == 0 || k == 5, pat(4'h0, 4'h1, k));
         if (k == 5) chk_bit("t3_proto", err_proto, 1'b1);
         if (k == 6) chk_bit("t3_proto_pulse", err_proto, 1'b0);
      end
      mcu_ncu_vld = 1'b0;
      chk_bit("t3_vld", pkt_vld, 1'b1);
      chk_vec("t3_data", pkt_data, P_0_1);
      chk_cnt("t3_count", pkt_count, 3'd7);
      chk_bit("t3_stall", ncu_mcu_stall, 1'b0);
      pop();
      chk_bit("t3_single", pkt_vld, 1'b0);

      // Full FIFO, pop in the same cycle as a new start
      send_pkt(4'h3, 4'h0, 1'b0);
      send_pkt(4'h8, 4'h3, 1'b0);
      chk_bit("t4_stall", ncu_mcu_stall, 1'b1);
      chk_vec("t4_head", pkt_data, P_3_0);
      pkt_rdy = 1'b1;
      nibble(1'b1, pat(4'h0, 4'h2, 0));
      pkt_rdy = 1'b0;
      chk_bit("t4_no_ovf", err_ovf, 1'b0);
      chk_bit("t4_stall_hold", ncu_mcu_stall, 1'b1);
      chk_vec("t4_head_after_pop", pkt_data, P_8_3);
      for (int k = 1; k < 32; k++) nibble(1'b0, pat(4'h0, 4'h2, k));
      chk_bit("t4_full_again", ncu_mcu_stall, 1'b1);
      chk_cnt("t4_count_sat", pkt_count, 3'd7);
      pop();
      chk_vec("t4_new_pkt", pkt_data, P_0_2);
      pop();
      chk_bit("t4_empty", pkt_vld, 1'b0);

      // Asynchronous reset mid-assembly
      send_pkt(4'h5, 4'h0, 1'b0);
      for (int k = 0; k < 10; k++) nibble(k == 0, pat(4'h0, 4'h1, k));
      chk_bit("t5_stall_pre", ncu_mcu_stall, 1'b1);
      rst_l = 1'b0;
      #1;
      chk_bit("t5_stall", ncu_mcu_stall, 1'b0);
      chk_bit("t5_pkt_vld", pkt_vld, 1'b0);
      chk_cnt("t5_count", pkt_count, '0);
      chk_vec("t5_data", pkt_data, '0);
      mcu_ncu_vld  = 1'b0;
      mcu_ncu_data = 4'h0;
      repeat (3) tick();
      rst_l = 1'b1;
      send_pkt(4'h0, 4'h1, 1'b1);
      chk_vec("t5_clean_data", pkt_data, P_0_1);
      chk_cnt("t5_clean_count", pkt_count, 3'd1);
      pop();

      // Counter saturation
      for (int i = 0; i < 5; i++) begin
         send_pkt(4'(i), 4'h1, 1'b0);
         pop();
      end
      chk_cnt("t6_count_near", pkt_count, 3'd6);
      for (int i = 0; i < 3; i++) begin
         send_pkt(4'h9, 4'h1, 1'b0);
         pop();
         chk_cnt("t6_count_sat", pkt_count, 3'd7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
